sunsoft_bank_irq_gen: RTL and testbench

- Parametrised Sunsoft-3-class mapper core. It provides:
  - a switchable 16 KB PRG window at $8000-$BFFF, with the last bank fixed at $C000-$FFFF;
  - either 4 CHR slots of 2 KB or 8 CHR slots of 1 KB;
  - four-mode nametable mirroring;
  - a CPU-cycle down-counter IRQ of configurable width, with optional auto-reload.
- It sits between the CPU/PPU bus decode and the PRG/CHR/CIRAM address muxes of a mapper top.

---
 rtl/sunsoft_bank_irq_gen_if.sv | 28 ++
 rtl/sunsoft_bank_irq_gen.sv | 205 ++++++++++++++++++++
 tb/tb_sunsoft_bank_irq_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sunsoft_bank_irq_gen_if.sv
// Bus bundle between the CPU/PPU address decode and the Sunsoft-3-class
// mapper core: CPU write port, PPU address, and the bank/CIRAM/IRQ results.
interface sunsoft_bank_irq_gen_if #(
    parameter int PRG_BW = 4,
    parameter int CHR_BW = 8
);
    logic [15:0]       cpu_addr;
    logic [7:0]        cpu_data;
    logic              cpu_rw;
    logic [13:0]       ppu_addr;
    logic [PRG_BW-1:0] prg_bank;
    logic [CHR_BW-1:0] chr_bank;
    logic              ciram_a10;
    logic              ciram_ce;
    logic              irq;

    // Bus decode side: drives addresses/data, consumes mapping results.
    modport master (
        output cpu_addr, cpu_data, cpu_rw, ppu_addr,
        input  prg_bank, chr_bank, ciram_a10, ciram_ce, irq
    );

    // Mapper core side.
    modport slave (
        input  cpu_addr, cpu_data, cpu_rw, ppu_addr,
        output prg_bank, chr_bank, ciram_a10, ciram_ce, irq
    );
endinterface

// File: rtl/sunsoft_bank_irq_gen.sv
// Sunsoft-3-class mapper core: switchable 16 KB PRG window with a fixed
// last bank, 4x2 KB or 8x1 KB CHR slots, four-mode mirroring and a
// CPU-cycle down-counter IRQ with optional auto-reload. All state is
// clocked on the falling edge of M2.
module sunsoft_bank_irq_gen #(
    parameter int PRG_BW     = 4,
    parameter int CHR_BW     = 8,
    parameter int CHR_SLOTS  = 4,
    parameter int IRQ_W      = 16,
    parameter int IRQ_RELOAD = 0
) (
    input  logic                     m2,
    input  logic                     map_rst,
    sunsoft_bank_irq_gen_if.slave    bus
);

    localparam int   CHR_IW    = (CHR_SLOTS == 8) ? 3 : 2;
    localparam logic RELOAD_EN = (IRQ_RELOAD != 0);

    // Reject parameter combinations the register map cannot express.
    generate
        if (!(CHR_SLOTS == 4 || CHR_SLOTS == 8)) begin : g_bad_slots
            $error("CHR_SLOTS must be 4 or 8");
        end
        if (IRQ_W < 9 || IRQ_W > 24) begin : g_bad_irq_w
            $error("IRQ_W must be in 9..24");
        end
        if (PRG_BW < 1 || PRG_BW > 8) begin : g_bad_prg_bw
            $error("PRG_BW must be in 1..8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [CHR_BW-1:0] chr_reg [CHR_SLOTS];
    logic [PRG_BW-1:0] prg_reg,       prg_next;
    logic [1:0]        mir_reg,       mir_next;
    logic [IRQ_W-1:0]  irq_ctr_reg,   irq_ctr_next;
    logic [IRQ_W-1:0]  irq_latch_reg;
    logic              irq_on_reg,    irq_on_next;
    logic              irq_rld_reg,   irq_rld_next;
    logic              irq_pend_reg,  irq_pend_next;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    logic              wr_en;
    logic              shift_wr;
    logic              ctrl_wr;
    logic              mir_wr;
    logic              prg_wr;
    logic              chr_wr;
    logic [CHR_IW-1:0] chr_wr_idx;
    logic [CHR_IW-1:0] chr_rd_idx;
    logic [CHR_BW-1:0] chr_wdata;
    logic [CHR_BW+7:0] chr_wdata_ext;
    logic [CHR_SLOTS-1:0] chr_we;
    logic              unused_bits;

    assign wr_en    = bus.cpu_addr[15] & ~bus.cpu_rw;
    assign chr_wr   = wr_en & ~bus.cpu_addr[14];
    assign shift_wr = wr_en & (bus.cpu_addr[14:12] == 3'd4);
    assign ctrl_wr  = wr_en & (bus.cpu_addr[14:12] == 3'd5);
    assign mir_wr   = wr_en & (bus.cpu_addr[14:12] == 3'd6);
    assign prg_wr   = wr_en & (bus.cpu_addr[14:12] == 3'd7);

    // Zero-extend (or truncate) the data byte to the CHR register width.
    assign chr_wdata_ext = {{CHR_BW{1'b0}}, bus.cpu_data};
    assign chr_wdata     = chr_wdata_ext[CHR_BW-1:0];

    // Slot index decode differs between 2 KB and 1 KB slot layouts.
    generate
        if (CHR_SLOTS == 8) begin : g_idx8
            assign chr_wr_idx = bus.cpu_addr[13:11];
            assign chr_rd_idx = bus.ppu_addr[12:10];
        end else begin : g_idx4
            assign chr_wr_idx = bus.cpu_addr[13:12];
            assign chr_rd_idx = bus.ppu_addr[12:11];
        end
    endgenerate

    // Address bits below the decode boundary carry no meaning here.
    assign unused_bits = ^{bus.cpu_addr[11:0], bus.ppu_addr[9:0]};

    // ------------------------------------------------------------------
    // CHR slot registers, one per slot
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < CHR_SLOTS; gi++) begin : g_chr
            assign chr_we[gi] = chr_wr & (chr_wr_idx == CHR_IW'(gi));

            // Slot register: cleared by reset, loaded by its CPU write.
            always_ff @(negedge m2) begin
                if (map_rst) begin
                    chr_reg[gi] <= '0;
                end else if (chr_we[gi]) begin
                    chr_reg[gi] <= chr_wdata;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // IRQ reload latch: only exists when auto-reload is built in
    // ------------------------------------------------------------------
    generate
        if (IRQ_RELOAD != 0) begin : g_latch
            // Latch shifts in parallel with the counter on $C000 writes.
            always_ff @(negedge m2) begin
                if (map_rst) begin
                    irq_latch_reg <= '0;
                end else if (shift_wr) begin
                    irq_latch_reg <= {irq_latch_reg[IRQ_W-9:0], bus.cpu_data};
                end
            end
        end else begin : g_no_latch
            assign irq_latch_reg = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state: countdown first, then CPU writes override it
    // ------------------------------------------------------------------
    // Countdown and register writes; a write to the same field wins.
    always_comb begin
        prg_next      = prg_reg;
        mir_next      = mir_reg;
        irq_ctr_next  = irq_ctr_reg;
        irq_on_next   = irq_on_reg;
        irq_rld_next  = irq_rld_reg;
        irq_pend_next = irq_pend_reg;

        if (irq_on_reg) begin
            if (irq_ctr_reg != '0) begin
                irq_ctr_next = irq_ctr_reg - 1'b1;
            end else begin
                irq_pend_next = 1'b1;
                if (irq_rld_reg) begin
                    irq_ctr_next = irq_latch_reg;
                end else begin
                    irq_ctr_next = '1;
                    irq_on_next  = 1'b0;
                end
            end
        end

        if (shift_wr) begin
            irq_ctr_next = {irq_ctr_reg[IRQ_W-9:0], bus.cpu_data};
        end
        if (ctrl_wr) begin
            irq_on_next   = bus.cpu_data[4];
            irq_rld_next  = bus.cpu_data[5] & RELOAD_EN;
            irq_pend_next = 1'b0;
        end
        if (mir_wr) begin
            mir_next = bus.cpu_data[1:0];
        end
        if (prg_wr) begin
            prg_next = bus.cpu_data[PRG_BW-1:0];
        end
    end

    // Register update; reset dominates everything on the same edge.
    always_ff @(negedge m2) begin
        if (map_rst) begin
            prg_reg      <= '0;
            mir_reg      <= '0;
            irq_ctr_reg  <= '0;
            irq_on_reg   <= 1'b0;
            irq_rld_reg  <= 1'b0;
            irq_pend_reg <= 1'b0;
        end else begin
            prg_reg      <= prg_next;
            mir_reg      <= mir_next;
            irq_ctr_reg  <= irq_ctr_next;
            irq_on_reg   <= irq_on_next;
            irq_rld_reg  <= irq_rld_next;
            irq_pend_reg <= irq_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Combinational outputs
    // ------------------------------------------------------------------
    logic ciram_a10_w;

    // Nametable A10 selection by mirroring mode.
    always_comb begin
        ciram_a10_w = bus.ppu_addr[10];
        case (mir_reg)
            2'd0:    ciram_a10_w = bus.ppu_addr[10];
            2'd1:    ciram_a10_w = bus.ppu_addr[11];
            2'd2:    ciram_a10_w = 1'b0;
            default: ciram_a10_w = 1'b1;
        endcase
    end

    assign bus.prg_bank  = bus.cpu_addr[14] ? {PRG_BW{1'b1}} : prg_reg;
    assign bus.chr_bank  = chr_reg[chr_rd_idx];
    assign bus.ciram_a10 = ciram_a10_w;
    assign bus.ciram_ce  = ~bus.ppu_addr[13];
    assign bus.irq       = irq_pend_reg;

endmodule

// File: tb/tb_sunsoft_bank_irq_gen.sv
// Scoreboard bench for sunsoft_bank_irq_gen. Two instances: "ua" with
// 8x1 KB CHR slots and one-shot IRQ, "ub" with 4x2 KB slots and
// auto-reload. Stimulus pushes expected values; a monitor on the rising
// M2 edge (state changes on the falling edge) pops and compares them.
module tb_sunsoft_bank_irq_gen;

    logic m2;
    logic rst_a;
    logic rst_b;

    sunsoft_bank_irq_gen_if #(.PRG_BW(4), .CHR_BW(8)) ifa ();
    sunsoft_bank_irq_gen_if #(.PRG_BW(4), .CHR_BW(8)) ifb ();

    sunsoft_bank_irq_gen #(
        .PRG_BW(4), .CHR_BW(8), .CHR_SLOTS(8), .IRQ_W(16), .IRQ_RELOAD(0)
    ) ua (
        .m2(m2), .map_rst(rst_a), .bus(ifa.slave)
    );

    sunsoft_bank_irq_gen #(
        .PRG_BW(4), .CHR_BW(8), .CHR_SLOTS(4), .IRQ_W(16), .IRQ_RELOAD(1)
    ) ub (
        .m2(m2), .map_rst(rst_b), .bus(ifb.slave)
    );

    initial m2 = 1'b1;
    always #5 m2 = ~m2;

    localparam int A_PRG = 0, A_CHR = 1, A_A10 = 2, A_CE = 3, A_IRQ = 4, A_CTR = 5, A_ON = 6;
    localparam int B_PRG = 10, B_CHR = 11, B_A10 = 12, B_CE = 13, B_IRQ = 14, B_CTR = 15, B_ON = 16;

    typedef struct {
        string name;
        int    sel;
        int    exp;
    } chk_t;

    chk_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int actual(input int sel);
        case (sel)
            A_PRG:   return int'(ifa.prg_bank);
            A_CHR:   return int'(ifa.chr_bank);
            A_A10:   return int'(ifa.ciram_a10);
            A_CE:    return int'(ifa.ciram_ce);
            A_IRQ:   return int'(ifa.irq);
            A_CTR:   return int'(ua.irq_ctr_reg);
            A_ON:    return int'(ua.irq_on_reg);
            B_PRG:   return int'(ifb.prg_bank);
            B_CHR:   return int'(ifb.chr_bank);
            B_A10:   return int'(ifb.ciram_a10);
            B_CE:    return int'(ifb.ciram_ce);
            B_IRQ:   return int'(ifb.irq);
            B_CTR:   return int'(ub.irq_ctr_reg);
            B_ON:    return int'(ub.irq_on_reg);
            default: return -1;
        endcase
    endfunction

    // Monitor: compare every queued expectation against the DUT outputs.
    initial begin
        forever begin
            @(posedge m2);
            while (sb.size() > 0) begin
                chk_t c;
                int   act;
                c   = sb.pop_front();
                act = actual(c.sel);
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h, expected %0h (t=%0t)", c.name, act, c.exp, $time);
                end else begin
                    $display("ok   %s: %0h", c.name, act);
                end
            end
        end
    end

    task automatic push(input string name, input int sel, input int exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sb.push_back(c);
    endtask

    // Let the monitor sample at the next rising edge.
    task automatic settle();
        @(posedge m2);
        #1;
    endtask

    // Advance one falling (state) edge.
    task automatic tick();
        @(negedge m2);
        #1;
    endtask

    task automatic wr_a(input logic [15:0] a, input logic [7:0] d);
        ifa.cpu_addr = a;
        ifa.cpu_data = d;
        ifa.cpu_rw   = 1'b0;
        tick();
        ifa.cpu_rw   = 1'b1;
        ifa.cpu_addr = 16'h0000;
    endtask

    task automatic wr_b(input logic [15:0] a, input logic [7:0] d);
        ifb.cpu_addr = a;
        ifb.cpu_data = d;
        ifb.cpu_rw   = 1'b0;
        tick();
        ifb.cpu_rw   = 1'b1;
        ifb.cpu_addr = 16'h0000;
    endtask

    initial begin
        ifa.cpu_addr = 16'h0000; ifa.cpu_data = 8'h00; ifa.cpu_rw = 1'b1; ifa.ppu_addr = 14'h0000;
        ifb.cpu_addr = 16'h0000; ifb.cpu_data = 8'h00; ifb.cpu_rw = 1'b1; ifb.ppu_addr = 14'h0000;
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tick();
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Reset defaults
        ifa.cpu_addr = 16'h8000;
        push("rst_prg_8000", A_PRG, 0);
        push("rst_irq", A_IRQ, 0);
        push("rst_ctr", A_CTR, 0);
        settle();
        ifa.cpu_addr = 16'hC000;
        ifa.ppu_addr = 14'h2400;
        push("rst_prg_c000", A_PRG, 4'hF);
        push("rst_a10_2400", A_A10, 1);
        push("rst_ce_2400", A_CE, 0);
        push("rst_chr", A_CHR, 0);
        settle();
        ifa.cpu_addr = 16'h0000;

        // CHR slots, 1 KB layout
        wr_a(16'h9800, 8'h55);
        wr_a(16'h9000, 8'hAA);
        ifa.ppu_addr = 14'h0C00; push("chr8_0c00", A_CHR, 8'h55); push("ce_0c00", A_CE, 1); settle();
        ifa.ppu_addr = 14'h0800; push("chr8_0800", A_CHR, 8'hAA); settle();
        ifa.ppu_addr = 14'h0000; push("chr8_0000", A_CHR, 0); settle();
        ifa.ppu_addr = 14'h1000; push("chr8_1000", A_CHR, 0); settle();
        ifa.ppu_addr = 14'h1C00; push("chr8_1c00", A_CHR, 0); settle();

        // Mirroring modes
        wr_a(16'hE000, 8'h01);
        ifa.ppu_addr = 14'h2800; push("mir1_2800", A_A10, 1); settle();
        ifa.ppu_addr = 14'h2400; push("mir1_2400", A_A10, 0); settle();
        wr_a(16'hE000, 8'h02);
        ifa.ppu_addr = 14'h2C00; push("mir2_2c00", A_A10, 0); settle();
        wr_a(16'hE000, 8'h03);
        ifa.ppu_addr = 14'h2000; push("mir3_2000", A_A10, 1); settle();
        wr_a(16'hE000, 8'h00);

        // PRG bank and non-writes
        wr_a(16'hF000, 8'h05);
        ifa.cpu_addr = 16'hA000; push("prg_a000", A_PRG, 5); settle();
        ifa.cpu_addr = 16'hE000; push("prg_e000", A_PRG, 4'hF); settle();
        ifa.cpu_addr = 16'hF000; ifa.cpu_data = 8'h09; ifa.cpu_rw = 1'b1; tick();
        ifa.cpu_addr = 16'h7000; ifa.cpu_data = 8'h0A; ifa.cpu_rw = 1'b0; tick();
        ifa.cpu_rw = 1'b1; ifa.cpu_addr = 16'h8000;
        push("prg_no_write", A_PRG, 5); settle();
        ifa.cpu_addr = 16'h0000;

        // One-shot IRQ: load 3, enable, expire on the 4th edge
        wr_a(16'hC000, 8'h00);
        wr_a(16'hC000, 8'h03);
        push("os_load", A_CTR, 3); settle();
        wr_a(16'hD000, 8'h10);
        push("os_en_irq", A_IRQ, 0); push("os_en_on", A_ON, 1); settle();
        for (int k = 1; k <= 4; k++) begin
            tick();
            push($sformatf("os_irq_e%0d", k), A_IRQ, (k == 4) ? 1 : 0);
            push($sformatf("os_ctr_e%0d", k), A_CTR, (k == 4) ? 16'hFFFF : 3 - k);
            push($sformatf("os_on_e%0d", k), A_ON, (k == 4) ? 0 : 1);
            settle();
        end
        tick();
        push("os_irq_hold", A_IRQ, 1); push("os_ctr_hold", A_CTR, 16'hFFFF); settle();
        wr_a(16'hD000, 8'h00);
        push("os_ack", A_IRQ, 0); settle();

        // Auto-reload IRQ on the second instance
        wr_b(16'hC000, 8'h02);
        wr_b(16'hD000, 8'h30);
        push("rl_e0_irq", B_IRQ, 0); push("rl_e0_ctr", B_CTR, 2); settle();
        tick(); push("rl_e1_irq", B_IRQ, 0); push("rl_e1_ctr", B_CTR, 1); settle();
        tick(); push("rl_e2_irq", B_IRQ, 0); push("rl_e2_ctr", B_CTR, 0); settle();
        tick(); push("rl_e3_irq", B_IRQ, 1); push("rl_e3_ctr", B_CTR, 2); push("rl_e3_on", B_ON, 1); settle();
        wr_b(16'hD000, 8'h30);
        push("rl_ack_irq", B_IRQ, 0); push("rl_ack_ctr", B_CTR, 1); settle();
        tick(); push("rl_e5_irq", B_IRQ, 0); push("rl_e5_ctr", B_CTR, 0); settle();
        tick(); push("rl_e6_irq", B_IRQ, 1); push("rl_e6_ctr", B_CTR, 2); settle();
        tick(); push("rl_e7_ctr", B_CTR, 1); settle();
        tick(); push("rl_e8_irq", B_IRQ, 1); push("rl_e8_ctr", B_CTR, 0); settle();

        // Collision: control write on the expiry edge
        wr_b(16'hD000, 8'h10);
        push("col_ctl_irq", B_IRQ, 0); push("col_ctl_on", B_ON, 1); push("col_ctl_ctr", B_CTR, 2); settle();
        // Collision: shift-in write overrides the decrement
        wr_b(16'hC000, 8'h07);
        push("col_shift_ctr", B_CTR, 16'h0207); settle();
        tick();
        push("col_after_ctr", B_CTR, 16'h0206); settle();

        // CHR slots, 2 KB layout
        wr_b(16'hA000, 8'h3C);
        ifb.ppu_addr = 14'h1000; push("chr4_1000", B_CHR, 8'h3C); settle();
        ifb.ppu_addr = 14'h1800; push("chr4_1800", B_CHR, 0); settle();

        // Mid-operation reset with a simultaneous PRG write
        rst_b = 1'b1; tick(); rst_b = 1'b0;
        wr_b(16'hC000, 8'h01);
        wr_b(16'hD000, 8'h30);
        tick();
        tick();
        push("mr_pre_irq", B_IRQ, 1); push("mr_pre_on", B_ON, 1); settle();
        ifb.cpu_addr = 16'hF000; ifb.cpu_data = 8'h05; ifb.cpu_rw = 1'b0; rst_b = 1'b1;
        tick();
        rst_b = 1'b0; ifb.cpu_rw = 1'b1; ifb.cpu_addr = 16'h8000;
        push("mr_irq", B_IRQ, 0); push("mr_prg", B_PRG, 0); push("mr_ctr", B_CTR, 0); push("mr_on", B_ON, 0);
        ifb.ppu_addr = 14'h1000; push("mr_chr", B_CHR, 0);
        settle();
        ifb.cpu_addr = 16'hC000; push("mr_prg_c000", B_PRG, 4'hF); settle();
        tick(); push("mr_irq_later", B_IRQ, 0); settle();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge m2);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d checks left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
